des_key_scheduler: RTL and testbench



---
 rtl/des_key_scheduler_pkg.sv | 56 +++++
 rtl/des_key_scheduler_key_rotator.sv | 40 ++++
 rtl/des_key_scheduler.sv | 151 +++++++++++++++
 tb/tb_des_key_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_scheduler_pkg.sv
// Shared constants for the DES key scheduler: PC-1/PC-2 tables, rotation
// schedule, FSM state type and the permutation helper functions.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int HALF_W   = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Entries are FIPS 46-3 bit numbers (1 = MSB) of the source vector.
  localparam int PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:CD_W] pc1(input logic [1:KEY_W] k);
    logic [1:CD_W] r;
    for (int i = 0; i < CD_W; i++) r[i+1] = k[PC1_TABLE[i]];
    return r;
  endfunction

  function automatic logic [1:SUBKEY_W] pc2(input logic [1:CD_W] cd);
    logic [1:SUBKEY_W] r;
    for (int i = 0; i < SUBKEY_W; i++) r[i+1] = cd[PC2_TABLE[i]];
    return r;
  endfunction

endpackage

// File: rtl/des_key_scheduler_key_rotator.sv
// Combinational rotate of the C and D halves by 0, 1 or 2 bits.
// Right rotation is only built when DES_DECRYPT_EN is defined.
module key_rotator
  import des_pkg::*;
(
  input  logic [1:HALF_W] c_in,
  input  logic [1:HALF_W] d_in,
  input  logic [1:0]      amount,
  input  logic            dir,
  output logic [1:HALF_W] c_out,
  output logic [1:HALF_W] d_out
);

  function automatic logic [1:HALF_W] rotl(input logic [1:HALF_W] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {x[2:HALF_W], x[1]};
      2'd2:    rotl = {x[3:HALF_W], x[1:2]};
      default: rotl = x;
    endcase
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [1:HALF_W] rotr(input logic [1:HALF_W] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {x[HALF_W], x[1:HALF_W-1]};
      2'd2:    rotr = {x[HALF_W-1:HALF_W], x[1:HALF_W-2]};
      default: rotr = x;
    endcase
  endfunction

  assign c_out = dir ? rotr(c_in, amount) : rotl(c_in, amount);
  assign d_out = dir ? rotr(d_in, amount) : rotl(d_in, amount);
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign c_out = rotl(c_in, amount);
  assign d_out = rotl(d_in, amount);
`endif

endmodule

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: PC-1 load, per-round rotation, PC-2 subkey
// over valid/ready. Define DES_DECRYPT_EN to honour mode (decrypt order).
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [1:KEY_W]      key,
  input  logic                mode,
  input  logic                abort,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [1:SUBKEY_W]   subkey,
  output logic [3:0]          round,
  output logic                done
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [1:HALF_W]   c_q, c_d, d_q, d_d;
  logic [1:HALF_W]   c_rot, d_rot;
  logic [1:SUBKEY_W] subkey_q, subkey_d;
  logic [3:0]        round_q, round_d;
  logic              subkey_valid_q, subkey_valid_d;
  logic [1:0]        rot_amount;
  logic              rot_dir;
  logic              last_accept;
  logic              unused_parity;

  assign unused_parity = ^{key[8], key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};

`ifdef DES_DECRYPT_EN
  logic       mode_q, mode_d;
  logic [3:0] dec_idx;

  // Decrypt walks the encrypt schedule backwards: round r undoes shift 16-r.
  assign dec_idx = 4'd0 - round_q;

  always_comb begin
    rot_dir = mode_q;
    if (!mode_q)               rot_amount = SHIFT_SCHED[round_q];
    else if (round_q == 4'd0)  rot_amount = 2'd0;
    else                       rot_amount = SHIFT_SCHED[dec_idx];
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rot_dir     = 1'b0;
  assign rot_amount  = SHIFT_SCHED[round_q];
`endif

  key_rotator u_rotator (
    .c_in   (c_q),
    .d_in   (d_q),
    .amount (rot_amount),
    .dir    (rot_dir),
    .c_out  (c_rot),
    .d_out  (d_rot)
  );

  // done is flagged in the accepting cycle itself so IDLE follows immediately.
  assign last_accept = (state_q == HOLD) && subkey_ready && !abort &&
                       (round_q == LAST_ROUND);

  always_comb begin
    state_d        = state_q;
    c_d            = c_q;
    d_d            = d_q;
    subkey_d       = subkey_q;
    round_d        = round_q;
    subkey_valid_d = subkey_valid_q;
`ifdef DES_DECRYPT_EN
    mode_d         = mode_q;
`endif
    if (abort) begin
      state_d        = IDLE;
      subkey_valid_d = 1'b0;
      round_d        = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            {c_d, d_d} = pc1(key);
            round_d    = 4'd0;
            state_d    = ROUND;
`ifdef DES_DECRYPT_EN
            mode_d     = mode;
`endif
          end
        end
        ROUND: begin
          c_d            = c_rot;
          d_d            = d_rot;
          subkey_d       = pc2({c_rot, d_rot});
          subkey_valid_d = 1'b1;
          state_d        = HOLD;
        end
        HOLD: begin
          if (subkey_ready) begin
            subkey_valid_d = 1'b0;
            if (round_q == LAST_ROUND) begin
              round_d = 4'd0;
              state_d = IDLE;
            end else begin
              round_d = round_q + 4'd1;
              state_d = ROUND;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      c_q            <= '0;
      d_q            <= '0;
      subkey_q       <= '0;
      round_q        <= 4'd0;
      subkey_valid_q <= 1'b0;
`ifdef DES_DECRYPT_EN
      mode_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      c_q            <= c_d;
      d_q            <= d_d;
      subkey_q       <= subkey_d;
      round_q        <= round_d;
      subkey_valid_q <= subkey_valid_d;
`ifdef DES_DECRYPT_EN
      mode_q         <= mode_d;
`endif
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = subkey_valid_q;
  assign subkey       = subkey_q;
  assign round        = round_q;
  assign done         = last_accept;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler: a cumulative-shift reference model
// fills a queue on each key; a negedge monitor pops and compares on handshake.
module tb_des_key_scheduler;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [1:64] key = '0;
  logic        key_ready, subkey_valid, done;
  logic [1:48] subkey;
  logic [3:0]  round;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int e_cyc = 0;
  int lat_v, lat_d;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rnd;
    bit          last;
  } exp_t;
  exp_t sb [$];
  logic [47:0] cap [16];

  always #5 clk = ~clk;

  des_key_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .mode         (mode),
    .abort        (abort),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Subkey n (0-based, encrypt order): halves rotated left by the running
  // total of the shift schedule, then compressed.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd, t;
    logic [47:0] sk;
    int s;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1_T[i]];
      d[27-i] = k[64-PC1_T[28+i]];
    end
    s = 0;
    for (int j = 0; j <= n; j++) s += SHIFTS[j];
    s = s % 28;
    t = {c, c} << s;
    c = t[55:28];
    t = {d, d} << s;
    d = t[55:28];
    cd = {c, d};
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2_T[i]];
    return sk;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       subkey_ready = 1'b1;
      1:       subkey_ready = pat[cyc % 4];
      default: subkey_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor
  bit          m_hs, m_exp_done, prev_valid, prev_hs;
  logic [47:0] prev_sk;
  logic [3:0]  prev_rnd;
  exp_t        m_e;
  initial begin
    prev_valid = 0;
    prev_hs = 0;
    prev_sk = '0;
    prev_rnd = '0;
    forever begin
      @(negedge clk);
      m_exp_done = 0;
      m_hs = rst_n && subkey_valid && subkey_ready && !abort;
      if (rst_n && prev_valid && !prev_hs && subkey_valid) begin
        chk("stall_subkey", {16'd0, subkey}, {16'd0, prev_sk});
        chk("stall_round", {60'd0, round}, {60'd0, prev_rnd});
      end
      if (m_hs) begin
        $display("subkey round=%0d value=%h", round, subkey);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_subkey: got round %0d value %h, none expected", round, subkey);
        end else begin
          m_e = sb.pop_front();
          chk("subkey", {16'd0, subkey}, {16'd0, m_e.sk});
          chk("round", {60'd0, round}, {60'd0, m_e.rnd});
          cap[round] = subkey;
          m_exp_done = m_e.last;
        end
      end
      if (rst_n && (done || m_exp_done))
        chk("done", {63'd0, done}, {63'd0, m_exp_done});
      prev_valid = rst_n && subkey_valid;
      prev_hs = m_hs;
      prev_sk = subkey;
      prev_rnd = round;
    end
  end

  task automatic issue_key(input logic [63:0] k, input bit m, input int rmode);
    bit dec;
    exp_t e;
`ifdef DES_DECRYPT_EN
    dec = m;
`else
    dec = 1'b0;
`endif
    for (int r = 0; r < 16; r++) begin
      e.sk = ref_subkey(k, dec ? 15 - r : r);
      e.rnd = 4'(r);
      e.last = (r == 15);
      sb.push_back(e);
    end
    ready_mode = rmode;
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key = k;
    mode = m;
    @(negedge clk);
    chk("key_ready_idle", {63'd0, key_ready}, 64'd1);
    @(posedge clk);
    #1;
    e_cyc = cyc;
    key_valid = 1'b0;
    key = {$urandom, $urandom};
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lv, output int ld);
    bit fin;
    fin = 0;
    lv = -1;
    ld = -1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (subkey_valid && lv < 0) lv = cyc - e_cyc;
      if (done) begin
        ld = cyc - e_cyc;
        fin = 1;
        break;
      end
    end
    #1;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 120 cycles, required one");
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_hold_round(input logic [3:0] r);
    bit found;
    found = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (subkey_valid && round == r) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout: round %0d never reached", r);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_key_ready"}, {63'd0, key_ready}, 64'd1);
    chk({tag, "_subkey_valid"}, {63'd0, subkey_valid}, 64'd0);
    chk({tag, "_round"}, {60'd0, round}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_idle_outputs("reset");
    chk("reset_subkey", {16'd0, subkey}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FIPS key, encrypt, ready always high: latency and known vectors
    issue_key(FIPS_KEY, 1'b0, 0);
    wait_done(lat_v, lat_d);
    chk("first_valid_latency", 64'(lat_v), 64'd1);
    chk("done_latency", 64'(lat_d), 64'd31);
    chk("fips_k1", {16'd0, cap[0]}, 64'h1B02EFFC7072);
    chk("fips_k2", {16'd0, cap[1]}, 64'h79AED9DBC9E5);
    chk("fips_k16", {16'd0, cap[15]}, 64'hCB3D8B0E17F5);

    // mode=1: reversed order when decrypt is built, ignored otherwise
    issue_key(FIPS_KEY, 1'b1, 0);
    wait_done(lat_v, lat_d);
`ifdef DES_DECRYPT_EN
    chk("dec_first", {16'd0, cap[0]}, 64'hCB3D8B0E17F5);
    chk("dec_last", {16'd0, cap[15]}, 64'h1B02EFFC7072);
`else
    chk("mode_ignored_first", {16'd0, cap[0]}, 64'h1B02EFFC7072);
    chk("mode_ignored_last", {16'd0, cap[15]}, 64'hCB3D8B0E17F5);
`endif

    // Ready toggling 1,0,0,1
    issue_key(FIPS_KEY, 1'b0, 1);
    wait_done(lat_v, lat_d);

    // Abort in HOLD round 5 with ready high
    issue_key(FIPS_KEY, 1'b0, 0);
    wait_hold_round(4'd5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_idle_outputs("abort");
    issue_key(FIPS_KEY, 1'b0, 0);
    wait_done(lat_v, lat_d);

    // key_valid with abort in IDLE must not load
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    abort = 1'b1;
    key = FIPS_KEY;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_key_ready", {63'd0, key_ready}, 64'd1);
    chk("abort_idle_valid", {63'd0, subkey_valid}, 64'd0);

    // Asynchronous reset mid-round 9
    issue_key(FIPS_KEY, 1'b0, 0);
    wait_hold_round(4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_subkey", {16'd0, subkey}, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue_key(64'h0123456789ABCDEF, 1'b0, 0);
    wait_done(lat_v, lat_d);

    // Zero key and parity-flipped FIPS key
    issue_key(64'h0, 1'b0, 2);
    wait_done(lat_v, lat_d);
    chk("zero_k8", {16'd0, cap[7]}, 64'd0);
    issue_key(FIPS_KEY ^ 64'h0101010101010101, 1'b0, 2);
    wait_done(lat_v, lat_d);
    chk("parity_k1", {16'd0, cap[0]}, 64'h1B02EFFC7072);
    chk("parity_k16", {16'd0, cap[15]}, 64'hCB3D8B0E17F5);

    // Random keys, modes and ready patterns
    for (int i = 0; i < 5; i++) begin
      issue_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 2);
      wait_done(lat_v, lat_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
